// File: rtl/rr_arbiter32_pkg.sv
// Shared types and constants for the 32-way round-robin arbiter.
// Holds the requester count, index width, FSM states and mask helper.
package rr_arbiter32_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bits strictly below idx; idx=0 yields an empty mask.
    function automatic logic [N_REQ-1:0] below_mask(
        input logic [IDX_W-1:0] idx
    );
        return (N_REQ'(1) << idx) - N_REQ'(1);
    endfunction

endpackage

// File: rtl/ffo_msb32.sv
// Combinational highest-set-bit finder over a 32-bit vector.
// Ports: vec (in), idx = index of highest set bit, any = vec != 0.
module ffo_msb32
    import rr_arbiter32_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last set bit seen is the highest.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/rr_arbiter32.sv
// Descending round-robin arbiter sharing one resource among 32 clients.
// Ports: clk, rst_n, req[31:0], release_i -> gnt_valid, gnt_idx,
// gnt_onehot, timeout (all outputs registered).
module rr_arbiter32
    import rr_arbiter32_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic             timeout
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   masked;
    logic [IDX_W-1:0]   m_idx, r_idx, winner;
    logic               m_any, r_any;
    logic               rel_end, drop_end, hold_end, grant_end;

    assign masked = req & below_mask(last_q);

    ffo_msb32 u_ffo_masked (
        .vec (masked),
        .idx (m_idx),
        .any (m_any)
    );

    ffo_msb32 u_ffo_raw (
        .vec (req),
        .idx (r_idx),
        .any (r_any)
    );

    // Prefer clients below the last winner; otherwise wrap to the top.
    assign winner = m_any ? m_idx : r_idx;

    assign rel_end   = release_i;
    assign drop_end  = ~req[gnt_idx_q];
    assign hold_end  = (MAX_HOLD != 0)
                     && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign grant_end = rel_end | drop_end | hold_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= '0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (r_any)     state_d = GRANT;
            GRANT:   if (grant_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d       = last_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (r_any) begin
                    gnt_valid_d  = 1'b1;
                    gnt_idx_d    = winner;
                    gnt_onehot_d = N_REQ'(1) << winner;
                    last_d       = winner;
                    hold_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                    // Release or a dropped request masks the timeout flag.
                    timeout_d    = hold_end & ~rel_end & ~drop_end;
                end else begin
                    hold_cnt_d   = hold_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Testbench for rr_arbiter32: directed scenarios plus random traffic
// compared against a behavioural round-robin model.
module tb_rr_arbiter32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        rel = 1'b0;

    logic        g_valid, h_valid;
    logic [4:0]  g_idx, h_idx;
    logic [31:0] g_oh, h_oh;
    logic        g_to, h_to;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_arbiter32 #(.MAX_HOLD(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_i  (rel),
        .gnt_valid  (g_valid),
        .gnt_idx    (g_idx),
        .gnt_onehot (g_oh),
        .timeout    (g_to)
    );

    rr_arbiter32 #(.MAX_HOLD(4), .CNT_W(16)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_i  (rel),
        .gnt_valid  (h_valid),
        .gnt_idx    (h_idx),
        .gnt_onehot (h_oh),
        .timeout    (h_to)
    );

    // Reference model: owner, grant age in cycles, last winner.
    typedef struct packed {
        logic        v;
        logic [4:0]  idx;
        logic [4:0]  last;
        logic [31:0] held;
        logic        to;
    } mst_t;

    mst_t m0, m1;

    // Search downward from just below last, then wrap from the top.
    function automatic logic [4:0] pick(logic [31:0] r, logic [4:0] last);
        for (int k = int'(last) - 1; k >= 0; k--)
            if (r[k]) return 5'(k);
        for (int k = 31; k >= 0; k--)
            if (r[k]) return 5'(k);
        return 5'd0;
    endfunction

    function automatic mst_t mstep(mst_t s, logic [31:0] r, logic rl,
                                   int mh);
        mst_t n = s;
        logic at_limit;
        n.to = 1'b0;
        at_limit = (mh != 0) && (s.held == 32'(mh));
        if (s.v) begin
            if (rl || !r[s.idx] || at_limit) begin
                n.v   = 1'b0;
                n.idx = 5'd0;
                n.to  = at_limit && !rl && r[s.idx];
            end else begin
                n.held = s.held + 1;
            end
        end else if (r != 0) begin
            n.idx  = pick(r, s.last);
            n.last = n.idx;
            n.v    = 1'b1;
            n.held = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= mstep(m0, req, rel, 16);
            m1 <= mstep(m1, req, rel, 4);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] r);
        rst_n = 1'b0;
        rel   = 1'b0;
        step();
        req   = r;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 32'hDEAD_BEEF;
        step();
        vectors++;
        if ({g_valid, g_idx, g_oh, g_to} !== '0) begin
            miscompares++;
            $display("FAIL reset_main got v=%b i=%0d oh=%h to=%b exp all 0",
                     g_valid, g_idx, g_oh, g_to);
        end
        vectors++;
        if ({h_valid, h_idx, h_oh, h_to} !== '0) begin
            miscompares++;
            $display("FAIL reset_h4 got v=%b i=%0d oh=%h to=%b exp all 0",
                     h_valid, h_idx, h_oh, h_to);
        end
    endtask

    task automatic run_order(input string nm, input logic [31:0] r,
                             input int exp_q[$]);
        logic [31:0] eoh;
        do_reset(r);
        step();
        foreach (exp_q[k]) begin
            eoh = 32'd1 << exp_q[k];
            vectors++;
            if (g_valid !== 1'b1 || g_idx !== 5'(exp_q[k])) begin
                miscompares++;
                $display("FAIL %s_grant%0d got v=%b i=%0d exp v=1 i=%0d",
                         nm, k, g_valid, g_idx, exp_q[k]);
            end
            vectors++;
            if (g_oh !== eoh) begin
                miscompares++;
                $display("FAIL %s_onehot%0d got %h exp %h",
                         nm, k, g_oh, eoh);
            end
            rel = 1'b1;
            step();
            vectors++;
            if (g_valid !== 1'b0 || g_oh !== 32'd0 || g_idx !== 5'd0) begin
                miscompares++;
                $display("FAIL %s_dead%0d got v=%b i=%0d oh=%h exp 0",
                         nm, k, g_valid, g_idx, g_oh);
            end
            rel = 1'b0;
            step();
        end
    endtask

    task automatic test_alternate();
        run_order("alt", 32'h8000_0001, '{31, 0, 31, 0});
    endtask

    task automatic test_order();
        run_order("order", 32'h0000_00F0, '{7, 6, 5, 4, 7});
    endtask

    task automatic test_timeout();
        int cnt = 0;
        do_reset(32'h0000_0004);
        step();
        while (g_valid === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        vectors++;
        if (cnt != 16) begin
            miscompares++;
            $display("FAIL to_len got %0d cycles exp 16", cnt);
        end
        vectors++;
        if (g_to !== 1'b1 || g_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse got to=%b v=%b exp to=1 v=0",
                     g_to, g_valid);
        end
        step();
        vectors++;
        if (g_to !== 1'b0 || g_valid !== 1'b1 || g_idx !== 5'd2) begin
            miscompares++;
            $display("FAIL to_regrant got to=%b v=%b i=%0d exp 0 1 2",
                     g_to, g_valid, g_idx);
        end
    endtask

    task automatic test_drop();
        do_reset(32'h0000_0300);
        step();
        vectors++;
        if (g_valid !== 1'b1 || g_idx !== 5'd9) begin
            miscompares++;
            $display("FAIL drop_first got v=%b i=%0d exp v=1 i=9",
                     g_valid, g_idx);
        end
        req = 32'h0000_0100;
        step();
        vectors++;
        if (g_valid !== 1'b0 || g_to !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_end got v=%b to=%b exp 0 0", g_valid, g_to);
        end
        step();
        vectors++;
        if (g_valid !== 1'b1 || g_idx !== 5'd8) begin
            miscompares++;
            $display("FAIL drop_next got v=%b i=%0d exp v=1 i=8",
                     g_valid, g_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset(32'h0010_0001);
        step();
        step();
        vectors++;
        if (g_valid !== 1'b1 || g_idx !== 5'd20) begin
            miscompares++;
            $display("FAIL arst_pre got v=%b i=%0d exp v=1 i=20",
                     g_valid, g_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({g_valid, g_idx, g_oh, g_to} !== '0) begin
            miscompares++;
            $display("FAIL arst_clear got v=%b i=%0d oh=%h exp 0",
                     g_valid, g_idx, g_oh);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (g_valid !== 1'b1 || g_idx !== 5'd20) begin
            miscompares++;
            $display("FAIL arst_first got v=%b i=%0d exp v=1 i=20",
                     g_valid, g_idx);
        end
    endtask

    task automatic test_rel_timeout();
        do_reset(32'h0000_0004);
        repeat (4) step();
        vectors++;
        if (h_valid !== 1'b1 || h_idx !== 5'd2) begin
            miscompares++;
            $display("FAIL rt_4th got v=%b i=%0d exp v=1 i=2",
                     h_valid, h_idx);
        end
        rel = 1'b1;
        step();
        vectors++;
        if (h_valid !== 1'b0 || h_to !== 1'b0) begin
            miscompares++;
            $display("FAIL rt_end got v=%b to=%b exp 0 0", h_valid, h_to);
        end
        rel = 1'b0;
        step();
        vectors++;
        if (h_valid !== 1'b1 || h_idx !== 5'd2 || h_to !== 1'b0) begin
            miscompares++;
            $display("FAIL rt_next got v=%b i=%0d to=%b exp 1 2 0",
                     h_valid, h_idx, h_to);
        end
    endtask

    task automatic test_random();
        logic [31:0] e0, e1;
        do_reset(32'h0);
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = $urandom;
                    1: req = 32'd1 << $urandom_range(0, 31);
                    2: req = $urandom & $urandom & $urandom;
                    default: req = '0;
                endcase
            end
            rel = ($urandom_range(0, 7) == 0);
            step();
            e0 = m0.v ? (32'd1 << m0.idx) : 32'd0;
            e1 = m1.v ? (32'd1 << m1.idx) : 32'd0;
            vectors++;
            if (g_valid !== m0.v || g_idx !== m0.idx
                || g_oh !== e0 || g_to !== m0.to) begin
                miscompares++;
                $display("FAIL rnd16 c=%0d got v=%b i=%0d oh=%h to=%b exp %b %0d %h %b",
                         c, g_valid, g_idx, g_oh, g_to,
                         m0.v, m0.idx, e0, m0.to);
            end
            vectors++;
            if (h_valid !== m1.v || h_idx !== m1.idx
                || h_oh !== e1 || h_to !== m1.to) begin
                miscompares++;
                $display("FAIL rnd4 c=%0d got v=%b i=%0d oh=%h to=%b exp %b %0d %h %b",
                         c, h_valid, h_idx, h_oh, h_to,
                         m1.v, m1.idx, e1, m1.to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_order();
        test_timeout();
        test_drop();
        test_async_reset();
        test_rel_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
